and16_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one `and16gate` bitwise-AND unit between `N_REQ` requesters.
- Each requester presents two 16-bit operands with a valid/ready handshake. The block grants one requester, registers its operands, drives them through the shared gate, and returns the registered result tagged with the requester index on a single response channel.
- It sits between the logic-gate library and any client logic that needs 16-bit AND results, and it removes the need to replicate the gate.

---
 rtl/and16_arbiter_pkg.sv | 5 +
 rtl/and16gate.sv | 10 +
 rtl/and16_arbiter.sv | 75 +++++++
 tb/tb_and16_arbiter.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/and16_arbiter_pkg.sv
// and16_arbiter_pkg: shared FSM encoding and operand width for the AND arbiter
package and16_arbiter_pkg;
  localparam int DATA_W = 16;
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;
endpackage

// File: rtl/and16gate.sv
// and16gate: 16-bit bitwise AND gate from the logic-gate library
module and16gate
  import and16_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  output logic [DATA_W-1:0] out
);
  assign out = x & y;
endmodule

// File: rtl/and16_arbiter.sv
// and16_arbiter: round-robin sharing of one and16gate between N_REQ requesters
module and16_arbiter
  import and16_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [DATA_W*N_REQ-1:0]  req_x,
  input  logic [DATA_W*N_REQ-1:0]  req_y,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     rsp_valid,
  output logic [DATA_W-1:0]        rsp_data,
  output logic [ID_W-1:0]          rsp_id,
  input  logic                     rsp_ready,
  output logic                     busy
);
  state_t r_state;
  logic [ID_W-1:0] r_ptr, r_id_q, w_pick, w_idx, w_next_ptr;
  logic [DATA_W-1:0] r_x_q, r_y_q, w_and;
  logic w_found, w_accept;
  // downward scan so the last hit is the one nearest at or after r_ptr
  always_comb begin
    w_pick = '0;
    w_found = 1'b0;
    w_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_idx = ID_W'((int'(r_ptr) + k) % N_REQ);
      if (req_valid[w_idx]) begin
        w_pick = w_idx;
        w_found = 1'b1;
      end
    end
  end
  assign w_accept = (r_state == IDLE) && !reset && w_found;
  assign req_ready = w_accept ? N_REQ'(1) << w_pick : '0;
  assign w_next_ptr = (int'(w_pick) == N_REQ - 1) ? '0 : w_pick + 1'b1;
  assign busy = (r_state != IDLE);
  and16gate u_gate (.x(r_x_q), .y(r_y_q), .out(w_and));
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_ptr <= '0;
      r_id_q <= '0;
      r_x_q <= '0;
      r_y_q <= '0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      rsp_id <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_x_q <= req_x[w_pick*DATA_W +: DATA_W];
          r_y_q <= req_y[w_pick*DATA_W +: DATA_W];
          r_id_q <= w_pick;
          r_ptr <= w_next_ptr;
          r_state <= EXEC;
        end
        EXEC: begin
          rsp_data <= w_and;
          rsp_id <= r_id_q;
          rsp_valid <= 1'b1;
          r_state <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_and16_arbiter.sv
// tb_and16_arbiter: directed stimulus with a queue scoreboard drained by a response monitor
module tb_and16_arbiter;
  localparam int N = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] req_valid = '0;
  logic [16*N-1:0] req_x = '0;
  logic [16*N-1:0] req_y = '0;
  logic [N-1:0] req_ready;
  logic rsp_valid;
  logic [15:0] rsp_data;
  logic [1:0] rsp_id;
  logic rsp_ready = 1'b1;
  logic busy;
  int checks = 0;
  int errors = 0;
  logic [17:0] exp_q[$];
  int grants[$];
  always #5 clk = ~clk;
  and16_arbiter #(.N_REQ(N)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .rsp_ready(rsp_ready), .busy(busy)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_req(input int id, input logic [15:0] x, input logic [15:0] y);
    req_x[id*16 +: 16] = x;
    req_y[id*16 +: 16] = y;
    req_valid[id] = 1'b1;
  endtask
  task automatic serve(input int id);
    @(negedge clk);
    chk("grant", 32'(req_ready), 32'(1 << id));
    tick();
    req_valid[id] = 1'b0;
    @(negedge clk);
    chk("exec_busy", 32'(busy), 1);
    chk("exec_no_rsp", 32'(rsp_valid), 0);
    tick();
    @(negedge clk);
    chk("rsp_valid", 32'(rsp_valid), 1);
    chk("rsp_id", 32'(rsp_id), 32'(id));
    tick();
  endtask
  // response monitor: every handshake must match the oldest expected response
  always @(negedge clk) begin
    if (!reset && (req_valid & req_ready) != '0)
      for (int i = 0; i < N; i++) if (req_ready[i]) grants.push_back(i);
    if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got id %0d data %0h expected none", rsp_id, rsp_data);
      end else begin
        logic [17:0] e;
        e = exp_q.pop_front();
        chk("rsp_data_id", 32'({rsp_id, rsp_data}), 32'(e));
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
  initial begin
    req_valid = 4'b1111;
    tick();
    repeat (2) begin
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rsp_data", 32'(rsp_data), 0);
      chk("rst_rsp_id", 32'(rsp_id), 0);
      chk("rst_busy", 32'(busy), 0);
      tick();
    end
    for (int i = 0; i < N; i++) set_req(i, 16'hFFFF, 16'(i));
    for (int i = 0; i < N; i++) exp_q.push_back({2'(i), 16'(i)});
    reset = 1'b0;
    for (int i = 0; i < N; i++) serve(i);
    // fairness: 0 and 2 held valid, pointer starts at 0
    grants.delete();
    set_req(0, 16'hF0F0, 16'h3C3C);
    set_req(2, 16'hAAAA, 16'h0FF0);
    for (int k = 0; k < 6; k++) exp_q.push_back((k % 2 == 0) ? {2'd0, 16'h3030} : {2'd2, 16'h0AA0});
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (grants.size() >= 6) break;
      tick();
    end
    tick();
    req_valid = '0;
    repeat (3) tick();
    chk("fair_count", 32'(grants.size()), 6);
    for (int k = 0; k < 6; k++)
      if (k < grants.size()) chk("fair_order", 32'(grants[k]), (k % 2 == 0) ? 0 : 2);
    set_req(1, 16'h1263, 16'h2462);
    exp_q.push_back({2'd1, 16'h0062});
    serve(1);
    @(negedge clk);
    chk("single_idle_busy", 32'(busy), 0);
    // backpressure on requester 3 while requester 0 waits
    rsp_ready = 1'b0;
    tick();
    set_req(3, 16'h00FF, 16'h0F0F);
    exp_q.push_back({2'd3, 16'h000F});
    @(negedge clk);
    chk("bp_grant", 32'(req_ready), 32'h8);
    tick();
    req_valid[3] = 1'b0;
    set_req(0, 16'h1111, 16'h1111);
    tick();
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", 32'(rsp_valid), 1);
      chk("bp_data", 32'(rsp_data), 32'h000F);
      chk("bp_id", 32'(rsp_id), 3);
      chk("bp_req_ready", 32'(req_ready), 0);
      chk("bp_busy", 32'(busy), 1);
      tick();
    end
    rsp_ready = 1'b1;
    req_valid = '0;
    tick();
    @(negedge clk);
    chk("bp_idle_busy", 32'(busy), 0);
    chk("bp_idle_valid", 32'(rsp_valid), 0);
    // reset during EXEC discards the operation and clears the pointer
    set_req(1, 16'hFFFF, 16'h1234);
    tick();
    req_valid = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_valid", 32'(rsp_valid), 0);
      chk("midrst_busy", 32'(busy), 0);
      tick();
    end
    set_req(1, 16'hFFFF, 16'h1234);
    set_req(3, 16'h8001, 16'hFFFF);
    exp_q.push_back({2'd1, 16'h1234});
    exp_q.push_back({2'd3, 16'h8001});
    serve(1);
    serve(3);
    repeat (2) tick();
    chk("drain", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
